endec: RTL and testbench

- Combined rate-1/n convolutional encoder and hard-decision Viterbi decoder with run-time code rate, constraint length and generator polynomials.
- The encoder is a bit-serial streaming path.
- The decoder processes one fixed-length frame of received symbols and returns the decoded data bits.
- The block sits between the framing logic and the channel interface; i_mode_sel selects the active path.

---
 rtl/endec.sv | 220 ++++++++++++++++++++++
 tb/tb_endec.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/endec.sv
// Rate-1/n convolutional encoder plus frame-based hard-decision Viterbi decoder.
// Define ENDEC_TAIL_FLUSH_EN to start traceback from state 0 (zero-terminated frames).
module endec #(
  parameter int MAX_CODE_RATE         = 3,
  parameter int MAX_CONSTRAINT_LENGTH = 9,
  parameter int DATA_FRAME_LENGTH     = 16,
  parameter int TRACEBACK_DEPTH       = 48,
  parameter bit ENCODE_MODE           = 1'b0,
  parameter bit DECODE_MODE           = 1'b1
) (
  input  logic                             sys_clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [MAX_CODE_RATE-1:0]         i_code_rate,
  input  logic [MAX_CONSTRAINT_LENGTH-1:0] i_constr_len,
  input  logic [MAX_CONSTRAINT_LENGTH-1:0] i_gen_poly [MAX_CODE_RATE],
  input  logic                             i_mode_sel,
  input  logic                             i_encoder_bit,
  input  logic [TRACEBACK_DEPTH-1:0]       i_decoder_data_frame,
  output logic [MAX_CODE_RATE-1:0]         o_encoder_data,
  output logic                             o_encoder_done,
  output logic [DATA_FRAME_LENGTH-1:0]     o_decoder_data,
  output logic                             o_decoder_done
);
  localparam int NR = MAX_CODE_RATE;
  localparam int KM = MAX_CONSTRAINT_LENGTH;
  localparam int L  = DATA_FRAME_LENGTH;
  localparam int SW = KM - 1;
  localparam int NS = 1 << SW;
  localparam int MW = $clog2(TRACEBACK_DEPTH + 1) + 1;
  localparam int BW = $clog2(NR + 1);
  localparam int CW = $clog2(L);
  localparam logic [MW-1:0] MAXM = {MW{1'b1}};

  typedef logic [NR-1:0][KM-1:0] poly_t;
  typedef enum logic [1:0] {IDLE, ACS, TRACE, DONE} st_t;

  function automatic logic [NR-1:0] enc_sym(input logic [KM-1:0] w, input poly_t g,
                                            input logic [NR-1:0] n, input logic [KM-1:0] k);
    logic [KM-1:0] km;
    logic [NR-1:0] o;
    km = '0;
    o  = '0;
    for (int i = 0; i < KM; i++) km[i] = (i < int'(k));
    for (int j = 0; j < NR; j++) o[j] = (j < int'(n)) ? ^(g[j] & w & km) : 1'b0;
    return o;
  endfunction

  function automatic logic [BW-1:0] hamming(input logic [NR-1:0] a, input logic [NR-1:0] b,
                                            input logic [NR-1:0] n);
    logic [BW-1:0] d;
    d = '0;
    for (int j = 0; j < NR; j++)
      if (j < int'(n) && (a[j] ^ b[j])) d = d + BW'(1);
    return d;
  endfunction

  // Unreachable states sit at MAXM and must stay there rather than wrap.
  function automatic logic [MW-1:0] sat_add(input logic [MW-1:0] a, input logic [BW-1:0] b);
    logic [MW:0] s;
    s = {1'b0, a} + (MW+1)'(b);
    if (a == MAXM || s >= {1'b0, MAXM}) return MAXM;
    return s[MW-1:0];
  endfunction

  logic  cfg_ok;
  poly_t poly_in;
  assign cfg_ok = (i_code_rate >= NR'(2)) && (i_code_rate <= NR'(NR)) &&
                  (i_constr_len >= KM'(3)) && (i_constr_len <= KM'(KM));
  always_comb
    for (int j = 0; j < NR; j++) poly_in[j] = i_gen_poly[j];

  // Encoder: window is {history, current bit}, history[0] = previous bit.
  logic [SW-1:0] enc_hist;
  logic          enc_go;
  assign enc_go = en && (i_mode_sel == ENCODE_MODE) && cfg_ok;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      enc_hist       <= '0;
      o_encoder_data <= '0;
      o_encoder_done <= 1'b0;
    end else begin
      o_encoder_done <= enc_go;
      if (enc_go) begin
        o_encoder_data <= enc_sym({enc_hist, i_encoder_bit}, poly_in, i_code_rate, i_constr_len);
        enc_hist       <= {enc_hist[SW-2:0], i_encoder_bit};
      end
    end
  end

  // Decoder control
  st_t st, st_nxt;
  logic start, acs_go, tr_go, done_go;
  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    if (en) begin
      case (st)
        IDLE:    if (i_mode_sel == DECODE_MODE && cfg_ok) st_nxt = ACS;
        ACS:     if (cnt == CW'(L-1)) st_nxt = TRACE;
        TRACE:   if (cnt == CW'(L-1)) st_nxt = DONE;
        default: st_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    start   = en && (st == IDLE) && (i_mode_sel == DECODE_MODE) && cfg_ok;
    acs_go  = en && (st == ACS);
    tr_go   = en && (st == TRACE);
    done_go = en && (st == DONE);
  end

  // Decoder datapath. State bit 0 is the newest input; a predecessor's MSB is the bit shifted out.
  logic [TRACEBACK_DEPTH-1:0] frame_q;
  logic [NR-1:0]              n_q;
  logic [KM-1:0]              k_q;
  poly_t                      g_q;
  logic [MW-1:0]              pm [NS];
  logic [MW-1:0]              npm [NS];
  logic [NS-1:0]              nsurv;
  logic [NS-1:0]              surv [L];
  logic [L-1:0]               dec_buf;
  logic [SW-1:0]              cur, sel, prev, start_st;
  logic [CW-1:0]              tidx;
  logic [NR-1:0]              sym_r;
  logic [KM-1:0]              w0, w1;
  logic [MW-1:0]              c0, c1;
  int                         ks, nk, p0, p1;

  always_comb begin
    ks    = (k_q < KM'(3)) ? 3 : int'(k_q);
    nk    = 1 << (ks - 1);
    sym_r = frame_q[int'(cnt)*NR +: NR];
    p0 = 0; p1 = 0; w0 = '0; w1 = '0; c0 = '0; c1 = '0;
    for (int s = 0; s < NS; s++) begin
      npm[s]   = MAXM;
      nsurv[s] = 1'b0;
      if (s < nk) begin
        p0 = s >> 1;
        p1 = p0 | (nk >> 1);
        w0 = KM'(s);
        w1 = KM'(s) | (KM'(1) << (ks - 1));
        c0 = sat_add(pm[SW'(p0)], hamming(enc_sym(w0, g_q, n_q, k_q), sym_r, n_q));
        c1 = sat_add(pm[SW'(p1)], hamming(enc_sym(w1, g_q, n_q, k_q), sym_r, n_q));
        if (c1 < c0) begin
          npm[s]   = c1;
          nsurv[s] = 1'b1;
        end else begin
          npm[s]   = c0;
        end
      end
    end
  end

`ifdef ENDEC_TAIL_FLUSH_EN
  assign start_st = '0;
`else
  logic [MW-1:0] bmet;
  always_comb begin
    start_st = '0;
    bmet     = pm[0];
    for (int s = 1; s < NS; s++)
      if (pm[s] < bmet) begin
        bmet     = pm[s];
        start_st = SW'(s);
      end
  end
`endif

  always_comb begin
    sel  = (cnt == '0) ? start_st : cur;
    tidx = CW'(L-1) - cnt;
    prev = (sel >> 1) | (SW'(surv[tidx][sel]) << (ks - 2));
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      for (int s = 0; s < NS; s++) pm[s] <= '0;
      for (int t = 0; t < L; t++) surv[t] <= '0;
      frame_q        <= '0;
      n_q            <= '0;
      k_q            <= '0;
      g_q            <= '0;
      cnt            <= '0;
      cur            <= '0;
      dec_buf        <= '0;
      o_decoder_data <= '0;
      o_decoder_done <= 1'b0;
    end else begin
      o_decoder_done <= done_go;
      if (start) begin
        frame_q <= i_decoder_data_frame;
        n_q     <= i_code_rate;
        k_q     <= i_constr_len;
        g_q     <= poly_in;
        cnt     <= '0;
        for (int s = 0; s < NS; s++) pm[s] <= (s == 0) ? '0 : MAXM;
      end
      if (acs_go) begin
        for (int s = 0; s < NS; s++) pm[s] <= npm[s];
        surv[cnt] <= nsurv;
        cnt       <= cnt + CW'(1);
      end
      if (tr_go) begin
        dec_buf[tidx] <= sel[0];
        cur           <= prev;
        cnt           <= cnt + CW'(1);
      end
      if (done_go) o_decoder_data <= dec_buf;
    end
  end
endmodule

// File: tb/tb_endec.sv
// Directed testbench for endec: encoder vectors, decode frames, stalls, bad config, reset abort.
module tb_endec;
  localparam int NR = 3;
  localparam int KM = 9;
  localparam int L  = 16;
  localparam int TD = 48;

  logic          sys_clk = 1'b0;
  logic          rst, en, i_mode_sel, i_encoder_bit;
  logic [NR-1:0] i_code_rate;
  logic [KM-1:0] i_constr_len;
  logic [KM-1:0] i_gen_poly [NR];
  logic [TD-1:0] i_decoder_data_frame;
  logic [NR-1:0] o_encoder_data;
  logic          o_encoder_done;
  logic [L-1:0]  o_decoder_data;
  logic          o_decoder_done;

  always #5 sys_clk = ~sys_clk;

  endec dut (
    .sys_clk(sys_clk), .rst(rst), .en(en),
    .i_code_rate(i_code_rate), .i_constr_len(i_constr_len), .i_gen_poly(i_gen_poly),
    .i_mode_sel(i_mode_sel), .i_encoder_bit(i_encoder_bit),
    .i_decoder_data_frame(i_decoder_data_frame),
    .o_encoder_data(o_encoder_data), .o_encoder_done(o_encoder_done),
    .o_decoder_data(o_decoder_data), .o_decoder_done(o_decoder_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct { logic bit_in; logic [NR-1:0] exp_sym; } evec_t;
  typedef struct { logic [TD-1:0] frame; logic [L-1:0] exp_data; int stall; int exp_lat; } dvec_t;

  // Start a decode from the current position (1 time unit after an edge); mode drops back
  // to ENCODE right after the start edge so the frame is not restarted.
  task automatic run_decode(input logic [TD-1:0] frame, input int stall,
                            output logic [L-1:0] res, output int lat, output int pulses);
    i_decoder_data_frame = frame;
    i_mode_sel = 1'b1;
    en = 1'b1;
    lat = 0; pulses = 0; res = '0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge sys_clk); #1;
      if (o_decoder_done) begin
        pulses++;
        if (lat == 0) begin lat = k; res = o_decoder_data; end
      end
      if (k == 1) i_mode_sel = 1'b0;
      if (stall != 0 && k == 2) en = 1'b0;
      if (stall != 0 && k == 7) en = 1'b1;
    end
  endtask

  evec_t ev [4];
  dvec_t dv [4];
  logic [TD-1:0] clean_f, zero_f;
  logic [NR-1:0] sym;
  logic [L-1:0]  res;
  int lat, pulses, cnt_e, cnt_d;

  initial begin
    rst = 1'b1; en = 1'b0; i_mode_sel = 1'b0; i_encoder_bit = 1'b0;
    i_code_rate = 3'd2; i_constr_len = 9'd3;
    i_gen_poly[0] = 9'b111; i_gen_poly[1] = 9'b101; i_gen_poly[2] = 9'b000;
    i_decoder_data_frame = '0;

    // Symbols (bit0 = g0, bit1 = g1) for data 1,0,1,1 then zeros.
    clean_f = '0;
    sym = 3'b011; clean_f[0  +: 3] = sym;
    sym = 3'b001; clean_f[3  +: 3] = sym;
    sym = 3'b010; clean_f[9  +: 3] = sym;
    sym = 3'b010; clean_f[12 +: 3] = sym;
    sym = 3'b011; clean_f[15 +: 3] = sym;
    zero_f = '0;

    ev[0] = '{1'b1, 3'b011};
    ev[1] = '{1'b0, 3'b001};
    ev[2] = '{1'b1, 3'b000};
    ev[3] = '{1'b1, 3'b010};

    dv[0] = '{zero_f, 16'h0000, 0, 34};
    dv[1] = '{clean_f, 16'h000D, 0, 34};
    dv[2] = '{clean_f ^ (48'h1 << 6), 16'h000D, 0, 34};
    dv[3] = '{clean_f, 16'h000D, 1, 39};

    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_enc_data", 64'(o_encoder_data), 64'h0);
    chk("rst_enc_done", 64'(o_encoder_done), 64'h0);
    chk("rst_dec_data", 64'(o_decoder_data), 64'h0);
    chk("rst_dec_done", 64'(o_decoder_done), 64'h0);
    rst = 1'b0;

    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_encoder_bit = ev[i].bit_in;
      @(posedge sys_clk); #1;
      chk($sformatf("enc_sym%0d", i), 64'(o_encoder_data), 64'(ev[i].exp_sym));
      chk($sformatf("enc_done%0d", i), 64'(o_encoder_done), 64'h1);
    end

    en = 1'b0;
    @(posedge sys_clk); #1;
    chk("enc_stall_done", 64'(o_encoder_done), 64'h0);
    chk("enc_stall_hold", 64'(o_encoder_data), 64'h2);

    for (int i = 0; i < 4; i++) begin
      run_decode(dv[i].frame, dv[i].stall, res, lat, pulses);
      chk($sformatf("dec_data%0d", i), 64'(res), 64'(dv[i].exp_data));
      chk($sformatf("dec_latency%0d", i), 64'(lat), 64'(dv[i].exp_lat));
      chk($sformatf("dec_pulses%0d", i), 64'(pulses), 64'h1);
    end

    // Invalid configurations: K=2 encode, n=1 encode, n=1 decode.
    en = 1'b1; i_mode_sel = 1'b0; i_constr_len = 9'd2; cnt_e = 0; cnt_d = 0;
    repeat (6) begin @(posedge sys_clk); #1; if (o_encoder_done) cnt_e++; end
    chk("bad_k_enc_pulses", 64'(cnt_e), 64'h0);
    i_constr_len = 9'd3; i_code_rate = 3'd1; cnt_e = 0;
    repeat (6) begin @(posedge sys_clk); #1; if (o_encoder_done) cnt_e++; end
    chk("bad_n_enc_pulses", 64'(cnt_e), 64'h0);
    i_mode_sel = 1'b1; i_decoder_data_frame = clean_f;
    repeat (40) begin @(posedge sys_clk); #1; if (o_decoder_done) cnt_d++; end
    chk("bad_n_dec_pulses", 64'(cnt_d), 64'h0);
    i_mode_sel = 1'b0; i_code_rate = 3'd2;
    @(posedge sys_clk); #1;

    // Reset in the middle of traceback, then a fresh frame.
    i_decoder_data_frame = clean_f; i_mode_sel = 1'b1; en = 1'b1; cnt_d = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge sys_clk); #1;
      if (o_decoder_done) cnt_d++;
      if (k == 1) i_mode_sel = 1'b0;
      if (k == 20) rst = 1'b1;
      if (k == 21) begin
        chk("abort_dec_data", 64'(o_decoder_data), 64'h0);
        chk("abort_enc_data", 64'(o_encoder_data), 64'h0);
        rst = 1'b0;
      end
    end
    chk("abort_no_done", 64'(cnt_d), 64'h0);
    run_decode(clean_f, 0, res, lat, pulses);
    chk("post_abort_data", 64'(res), 64'h000D);
    chk("post_abort_latency", 64'(lat), 64'd34);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
